// File: rtl/way_alloc_ctrl_if.sv
// Request/response, LRU side-channel and occupancy signals of the way allocation controller.
interface way_alloc_ctrl_if #(
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 8
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int CNT_W = $clog2(NUM_WAYS) + 1;

  logic                req_valid_i;
  logic [1:0]          req_op_i;
  logic [TAG_W-1:0]    req_tag_i;
  logic                req_ready_o;
  logic                resp_valid_o;
  logic                resp_ready_i;
  logic                resp_hit_o;
  logic [WAY_W-1:0]    resp_way_o;
  logic                resp_err_o;
  logic                ls_valid_o;
  logic [1:0]          ls_op_o;
  logic [WAY_W-1:0]    ls_way_o;
  logic                lru_valid_i;
  logic [NUM_WAYS-1:0] lru_way_i;
  logic [CNT_W-1:0]    valid_cnt_o;

  modport master (
    output req_valid_i, req_op_i, req_tag_i, resp_ready_i, lru_valid_i, lru_way_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_err_o,
           ls_valid_o, ls_op_o, ls_way_o, valid_cnt_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_tag_i, resp_ready_i, lru_valid_i, lru_way_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_err_o,
           ls_valid_o, ls_op_o, ls_way_o, valid_cnt_o
  );
endinterface

// File: rtl/way_alloc_ctrl.sv
// Tag/valid store of one fully-associative set: looks up, allocates (via external LRU)
// and invalidates ways, one request at a time through an IDLE/LOOKUP/RESP sequence.
module way_alloc_ctrl #(
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  way_alloc_ctrl_if.slave bus
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int CNT_W = $clog2(NUM_WAYS) + 1;

  localparam logic [1:0] OP_RSVD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_INV   = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    tags_q [NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]    valid_cnt_q, valid_cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic                resp_err_q, resp_err_d;
  logic [WAY_W-1:0]    resp_way_q, resp_way_d;

  logic                accept;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                alloc_ok;
  logic [WAY_W-1:0]    alloc_way;
  logic                tag_we;

  assign accept = (state_q == IDLE) && bus.req_valid_i;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (valid_q[i] && (tags_q[i] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

  always_comb begin
    alloc_ok  = bus.lru_valid_i && (bus.lru_way_i != '0) &&
                ((bus.lru_way_i & (bus.lru_way_i - NUM_WAYS'(1))) == '0);
    alloc_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (bus.lru_way_i[i]) alloc_way = WAY_W'(i);
    end
  end

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    resp_valid_d    = resp_valid_q;
    resp_hit_d      = resp_hit_q;
    resp_way_d      = resp_way_q;
    resp_err_d      = resp_err_q;
    tag_we          = 1'b0;
    bus.ls_valid_o  = 1'b0;
    bus.ls_op_o     = 2'b00;
    bus.ls_way_o    = '0;
    bus.req_ready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_d = LOOKUP;
      end
      LOOKUP: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_hit_d   = 1'b0;
        resp_way_d   = '0;
        resp_err_d   = 1'b0;
        unique case (op_q)
          OP_LOAD: begin
            if (hit) begin
              bus.ls_valid_o = 1'b1;
              bus.ls_op_o    = OP_LOAD;
              bus.ls_way_o   = hit_way;
              resp_hit_d     = 1'b1;
              resp_way_d     = hit_way;
            end
          end
          OP_STORE: begin
            bus.ls_valid_o = 1'b1;
            if (hit) begin
              bus.ls_op_o  = OP_LOAD;
              bus.ls_way_o = hit_way;
              resp_hit_d   = 1'b1;
              resp_way_d   = hit_way;
            end else begin
              // The LRU answers combinationally to this store pulse within the same cycle.
              bus.ls_op_o = OP_STORE;
              if (alloc_ok) begin
                tag_we             = 1'b1;
                valid_d[alloc_way] = 1'b1;
                resp_way_d         = alloc_way;
              end else begin
                resp_err_d = 1'b1;
              end
            end
          end
          OP_INV: begin
            if (hit) begin
              bus.ls_valid_o   = 1'b1;
              bus.ls_op_o      = OP_INV;
              bus.ls_way_o     = hit_way;
              valid_d[hit_way] = 1'b0;
              resp_hit_d       = 1'b1;
              resp_way_d       = hit_way;
            end
          end
          OP_RSVD: resp_err_d = 1'b1;
          default: resp_err_d = 1'b1;
        endcase
      end
      RESP: begin
        if (bus.resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_hit_d   = 1'b0;
          resp_way_d   = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_cnt_d = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      valid_cnt_d = valid_cnt_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      valid_cnt_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      valid_cnt_q  <= valid_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request capture and tag array carry no reset; valid bits alone qualify the tags.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= bus.req_op_i;
      tag_q <= bus.req_tag_i;
    end
    if (tag_we) tags_q[alloc_way] <= tag_q;
  end

  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_hit_o   = resp_hit_q;
  assign bus.resp_way_o   = resp_way_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.valid_cnt_o  = valid_cnt_q;
endmodule
